// File: rtl/sensor_conditioner.sv
// Moisture block averager and debounced light-level classifier feeding the irrigation FSM.
// Optional stuck-sample fault detection is compiled in with `define SENSOR_FAULT_EN.
module sensor_conditioner #(
  parameter int unsigned AVG_LOG2  = 3,
  parameter logic [6:0]  L_T1      = 7'd20,
  parameter logic [6:0]  L_T2      = 7'd60,
  parameter logic [6:0]  L_T3      = 7'd100,
  parameter logic [6:0]  L_HYST    = 7'd5,
  parameter int unsigned PERSIST   = 4,
  parameter int unsigned FAULT_CNT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic [6:0] m_raw,
  input  logic [6:0] l_raw,
  output logic [6:0] m_avg,
  output logic       m_valid,
  output logic [1:0] l_level,
  output logic       l_change,
  output logic       sensor_fault
);

  localparam int unsigned ACC_W = 7 + AVG_LOG2;
  localparam logic [6:0] THR [1:3] = '{L_T1, L_T2, L_T3};

  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [6:0]          m_avg_q, m_avg_d, avg_trunc;
  logic                m_valid_q, m_valid_d;
  logic [1:0]          level_q, level_d, tgt_q, tgt_d, cand;
  logic [3:0]          pcnt_q, pcnt_d, pinc;
  logic                change_q, change_d, up_found;
  logic                fault;

  assign sum       = acc_q + ACC_W'(m_raw);
  assign avg_trunc = 7'(sum >> AVG_LOG2);

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    m_avg_d   = m_avg_q;
    m_valid_d = 1'b0;
    if (sample_valid) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        acc_d     = '0;
        m_avg_d   = avg_trunc;
        m_valid_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  // Thresholds ascend, so the lowest crossed threshold alone decides a downward move.
  always_comb begin
    cand     = level_q;
    up_found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (2'(k) > level_q && l_raw >= THR[k]) begin
        cand     = 2'(k);
        up_found = 1'b1;
      end
    end
    if (!up_found) begin
      for (int k = 2; k >= 0; k--) begin
        if (2'(k) < level_q &&
            l_raw < ((THR[k+1] > L_HYST) ? THR[k+1] - L_HYST : 7'd0))
          cand = 2'(k);
      end
    end
  end

  always_comb begin
    pcnt_d   = pcnt_q;
    tgt_d    = tgt_q;
    level_d  = level_q;
    change_d = 1'b0;
    pinc     = 4'd0;
    if (sample_valid && !fault) begin
      if (cand == level_q) begin
        pcnt_d = 4'd0;
      end else begin
        if (cand != tgt_q) begin
          tgt_d = cand;
          pinc  = 4'd1;
        end else begin
          pinc = pcnt_q + 4'd1;
        end
        if (pinc == 4'(PERSIST)) begin
          level_d  = tgt_d;
          change_d = 1'b1;
          pcnt_d   = 4'd0;
        end else begin
          pcnt_d = pinc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      m_avg_q   <= 7'd127;
      m_valid_q <= 1'b0;
      level_q   <= 2'd0;
      tgt_q     <= 2'd0;
      pcnt_q    <= 4'd0;
      change_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      m_avg_q   <= m_avg_d;
      m_valid_q <= m_valid_d;
      level_q   <= level_d;
      tgt_q     <= tgt_d;
      pcnt_q    <= pcnt_d;
      change_q  <= change_d;
    end
  end

`ifdef SENSOR_FAULT_EN
  logic [4:0] mf_q, mf_d, lf_q, lf_d;
  logic       fault_q, fault_d;

  // Counters saturate so a long stuck run cannot wrap back below the trip point.
  always_comb begin
    mf_d    = mf_q;
    lf_d    = lf_q;
    fault_d = fault_q;
    if (sample_valid) begin
      if (m_raw == 7'd0 || m_raw == 7'd127) begin
        if (mf_q != 5'(FAULT_CNT)) mf_d = mf_q + 5'd1;
      end else begin
        mf_d = 5'd0;
      end
      if (l_raw == 7'd0 || l_raw == 7'd127) begin
        if (lf_q != 5'(FAULT_CNT)) lf_d = lf_q + 5'd1;
      end else begin
        lf_d = 5'd0;
      end
      if (mf_d == 5'(FAULT_CNT) || lf_d == 5'(FAULT_CNT)) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mf_q    <= 5'd0;
      lf_q    <= 5'd0;
      fault_q <= 1'b0;
    end else begin
      mf_q    <= mf_d;
      lf_q    <= lf_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign m_avg        = fault ? 7'd127 : m_avg_q;
  assign m_valid      = m_valid_q & ~fault;
  assign l_level      = level_q;
  assign l_change     = change_q;
  assign sensor_fault = fault;

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
Upstream stage of the irrigation FSM. Takes raw 7-bit moisture and light ADC samples, each qualified by a valid strobe. Produces two outputs for the FSM's m_sense and l_thresh inputs:
- a block-averaged moisture value;
- a debounced 2-bit light level with hysteresis.

This keeps ADC noise and passing shadows from causing spurious watering or dawn detection.

Parameters:
AVG_LOG2, 3, log2 of moisture samples per average block (block = 8 samples)
L_T1, 7'd20, light raw threshold, level 0 -> 1 (dark -> dawn)
L_T2, 7'd60, light raw threshold, level 1 -> 2 (dawn -> day)
L_T3, 7'd100, light raw threshold, level 2 -> 3 (day -> bright)
L_HYST, 7'd5, downward hysteresis margin
PERSIST, 4, consecutive light samples needed to accept a level change (1..15)
FAULT_CNT, 16, stuck-sample count for fault flag (feature only)

Ports:
clk  in  1  system clock (same domain as the ADC interface)
rst_n  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe; m_raw and l_raw valid this cycle
m_raw  in  7  raw moisture ADC sample
l_raw  in  7  raw light ADC sample
m_avg  out  7  averaged moisture, to FSM m_sense
m_valid  out  1  one-cycle pulse when m_avg updates
l_level  out  2  debounced light level, to FSM l_thresh
l_change  out  1  one-cycle pulse when l_level changes
sensor_fault  out  1  sticky fault flag (SENSOR_FAULT_EN only; else tied 0)

Behaviour:
- Reset (async assert, sync deassert at the next clk edge is not required):
  - m_avg=7'd127 (reads "wet", so no watering at power-up).
  - m_valid=0, l_level=2'd0, l_change=0, sensor_fault=0.
  - Accumulator, sample counter, persistence counter and fault counters cleared.
- All state advances only on cycles with sample_valid=1. With sample_valid=0, all state holds and pulses are 0.
- Moisture averaging:
  - Accumulator is 7+AVG_LOG2 bits unsigned and cannot overflow.
  - Sample counter is AVG_LOG2 bits.
  - On each valid sample: acc += m_raw and cnt += 1.
  - On the valid sample where cnt == 2^AVG_LOG2-1 (the block's last sample):
    - m_avg <= (acc + m_raw) >> AVG_LOG2 (truncating);
    - m_valid pulses on the next cycle (registered, latency 1 clk from that strobe);
    - acc is cleared, and cnt wraps to 0.
  - Blocks are non-overlapping; no output between blocks.
- Light candidate, combinational from l_raw and current l_level=L. Each level k has threshold Tk (T1=L_T1, T2=L_T2, T3=L_T3).
  - Up: candidate = highest k > L with l_raw >= Tk.
  - Else down: candidate = lowest k < L such that l_raw < T(k+1) - L_HYST for every threshold crossed between k and L.
  - Else candidate = L. Multi-level jumps are allowed.
  - Threshold subtraction saturates at 0.
- Persistence, 4-bit counter pcnt, with tracked target tgt:
  - On each valid sample, if candidate == L: pcnt <= 0.
  - Else if candidate != tgt: tgt <= candidate and pcnt <= 1.
  - Else pcnt <= pcnt + 1.
  - When the incremented count reaches PERSIST: l_level <= tgt, l_change pulses 1 cycle later-registered (same edge as the l_level update), and pcnt <= 0.
  - PERSIST=1 means an immediate change on the first differing sample.
- Simultaneous events: a moisture block completion and a light change on the same sample are independent; both pulses may assert together.
- Reset mid-block discards the partial accumulation. m_avg returns to 127.

Optional Feature:
SENSOR_FAULT_EN:
- Defined: two 5-bit counters, one per channel, count consecutive valid samples whose raw value is 0 or 127.
  - A counter clears on any in-range sample.
  - When either counter reaches FAULT_CNT, sensor_fault sets and stays set until rst_n.
  - While sensor_fault=1, m_avg is forced to 7'd127 and m_valid stops pulsing, which inhibits watering. l_level is held.
- Undefined: no counters; sensor_fault is constant 0.

Test Plan:
- Reset: rst_n low mid-operation -> m_avg=127, l_level=0, all pulses 0 immediately (async), no clk needed.
- Averaging: 8 valid samples m_raw=10,20,...,80 -> m_valid one pulse after the 8th strobe, m_avg=45. The next 7 samples give no pulse.
- Truncation: 8 samples of 7'd127 then 8 samples alternating 0/1 -> m_avg=127, then m_avg=0.
- Light up with persistence: l_level=0, l_raw=25 for 3 samples then 10 -> no change. l_raw=25 for 4 samples -> l_level=1 and l_change pulses on the 4th.
- Hysteresis: l_level=1, l_raw=17 ×4 -> stays 1 (17 >= 20-5). l_raw=14 ×4 -> l_level=0. l_raw=110 ×4 from 0 -> jumps to 3.
- Fault (SENSOR_FAULT_EN): m_raw=0 for 16 valid samples -> sensor_fault=1, m_avg=127. Normal samples afterward -> fault stays 1 until rst_n.
